// File: rtl/fp32Pkg.sv
// IEEE-754 single-precision field layout shared across the FP unit.
package fp32Pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] sig;
  } fp32_t;
endpackage

// File: rtl/fp64Pkg.sv
// IEEE-754 double-precision field layout shared across the FP unit.
package fp64Pkg;
  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] sig;
  } fp64_t;
endpackage

// File: rtl/fp_cvt_sched_pkg.sv
// Shared types and constants for the FP32->FP64 conversion scheduler.
package fpCvtSchedPkg;
  import fp64Pkg::*;

  localparam int          CVT_FIFO_DEPTH = 2;
  localparam logic [10:0] CVT_BIAS_DIFF  = 11'h380;
  // Entry fields are sized for the largest supported NREQ (8) and tag width.
  localparam int          CVT_ID_MAXW    = 3;
  localparam int          CVT_TAG_MAXW   = 16;

  typedef struct packed {
    fp64_t                   data;
    logic [CVT_ID_MAXW-1:0]  id;
    logic [CVT_TAG_MAXW-1:0] tag;
    logic                    dnm;
  } cvt_entry_t;
endpackage

// File: rtl/fp_cvt_sched_cvt.sv
// Combinational FP32->FP64 widening; exponent-0 inputs are left to the caller.
module fpCvt32To64
  import fp32Pkg::*;
  import fp64Pkg::*;
  import fpCvtSchedPkg::*;
(
  input  fp32_t a,
  output fp64_t y
);

  always_comb begin
    y.sign = a.sign;
    y.exp  = (a.exp == 8'hFF) ? 11'h7FF : ({3'b000, a.exp} + CVT_BIAS_DIFF);
    y.sig  = {a.sig, 29'b0};
  end

endmodule

// File: rtl/fp_cvt_sched.sv
// Round-robin scheduler sharing one FP32->FP64 converter among NREQ requesters,
// with zero/denormal fixup and a 2-entry result FIFO.
module fp_cvt_sched
  import fp32Pkg::*;
  import fp64Pkg::*;
  import fpCvtSchedPkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int TAGW = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [IDW-1:0]       out_id,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_dnm,
  output logic                 busy
);

  localparam logic [1:0] FULL = 2'(CVT_FIFO_DEPTH);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gid_p0;
  logic [IDW-1:0]  nxt_ptr;
  logic [NREQ-1:0] grant_p0;
  logic            gnt_any_p0;
  logic            vld_p0;
  logic            pop;
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  fp32_t           op_p0;
  fp64_t           cvt_p0;
  logic [TAGW-1:0] tag_p0;
  cvt_entry_t      ent_p0;
  cvt_entry_t      fifo_p1 [CVT_FIFO_DEPTH];
  cvt_entry_t      head_p1;

  function automatic fp64_t zero_fixup(input fp32_t a, input fp64_t c);
    fp64_t z;
    z = c;
    if (a.exp == 8'h00) begin
      z.exp = '0;
      z.sig = '0;
    end
    return z;
  endfunction

  function automatic logic is_dnm(input fp32_t a);
    return (a.exp == 8'h00) && (a.sig != '0);
  endfunction

  // ---- p0: arbitration, operand select, conversion ----
  always_comb begin : arb
    int j;
    grant_p0   = '0;
    gid_p0     = '0;
    gnt_any_p0 = 1'b0;
    j          = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any_p0 && req_valid[j]) begin
        gnt_any_p0  = 1'b1;
        grant_p0[j] = 1'b1;
        gid_p0      = IDW'(j);
      end
    end
  end

  // Ready is gated by FIFO occupancy only, never by out_ready.
  assign req_ready = (rst_n && (count < FULL)) ? grant_p0 : '0;
  assign vld_p0    = |(req_valid & req_ready);
  assign pop       = (count != 2'd0) && out_ready;
  assign nxt_ptr   = (gid_p0 == IDW'(NREQ - 1)) ? '0 : (gid_p0 + IDW'(1));

  assign op_p0  = req_data[32*gid_p0 +: 32];
  assign tag_p0 = req_tag[TAGW*gid_p0 +: TAGW];

  fpCvt32To64 u_cvt (
    .a (op_p0),
    .y (cvt_p0)
  );

  always_comb begin
    ent_p0      = '0;
    ent_p0.data = zero_fixup(op_p0, cvt_p0);
    ent_p0.id   = CVT_ID_MAXW'(gid_p0);
    ent_p0.tag  = CVT_TAG_MAXW'(tag_p0);
    ent_p0.dnm  = is_dnm(op_p0);
  end

  // ---- p1: result FIFO ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rr_ptr <= '0;
    end else begin
      count <= count + {1'b0, vld_p0} - {1'b0, pop};
      if (vld_p0) begin
        wr_ptr <= ~wr_ptr;
        rr_ptr <= nxt_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) fifo_p1[wr_ptr] <= ent_p0;
  end

  // Storage is not reset; an empty FIFO presents zeros on the result fields.
  assign head_p1   = fifo_p1[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? head_p1.data : '0;
  assign out_id    = out_valid ? head_p1.id[IDW-1:0] : '0;
  assign out_tag   = out_valid ? head_p1.tag[TAGW-1:0] : '0;
  assign out_dnm   = out_valid & head_p1.dnm;
  assign busy      = out_valid | (|req_valid);

endmodule

// File: doc/fp_cvt_sched.md
# fp_cvt_sched

Round-robin scheduler that shares one single-to-double precision converter among `NREQ` requesters. Each requester presents an FP32 operand and a tag through a valid/ready handshake. The scheduler grants one requester per cycle, fixes up zero and denormal operands, and registers the FP64 result. Results go through a 2-entry output FIFO that tolerates backpressure. It sits between the issue ports of the FP unit and the writeback path.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TAGW`, 4: tag width returned with each result.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NREQ: requester k has an operand.
- `req_ready`  out  NREQ: requester k accepted this cycle; at most one bit set.
- `req_data`  in  NREQ*32: FP32 operands; requester k is in bits [32k+31:32k].
- `req_tag`  in  NREQ*TAGW: tags, packed the same way.
- `out_valid`  out  1: the FIFO head is valid.
- `out_ready`  in  1: the consumer takes the head.
- `out_data`  out  64: FP64 result.
- `out_id`  out  $clog2(NREQ): index of the originating requester.
- `out_tag`  out  TAGW: tag copied from the request.
- `out_dnm`  out  1: the input was denormal and was flushed to signed zero.
- `busy`  out  1: FIFO not empty, or any `req_valid` is high.

## Operation
- **Grant:** the grant goes to the first requester with `req_valid` set, scanning from `rr_ptr` upward and wrapping mod NREQ.
  - `req_ready[k] = grant[k] & (count < 2)`.
  - `req_ready` does not depend combinationally on `out_ready`.
- **Transfer:** a transfer happens when `req_valid[k] & req_ready[k]`. On a transfer, `rr_ptr` becomes `(k+1) mod NREQ`. With no transfer, `rr_ptr` holds.
- **Conversion of the accepted operand:**
  - sign copied from the input;
  - exp 0xFF gives exp 0x7FF;
  - any other nonzero exp e gives exp e + 0x380;
  - significand is `{sig, 29'b0}`.
- **Zero fixup:** input exp 0 produces a signed zero, exp 0 and sig 0. `out_dnm` is set when the input sig is nonzero.
  - +0.0 becomes 0x0000_0000_0000_0000.
  - -0.0 becomes 0x8000_0000_0000_0000.
- **FIFO:** depth 2, holding data, id, tag and dnm. Push on a transfer, pop on `out_valid & out_ready`.
  - A simultaneous push and pop leaves `count` unchanged.
  - Order is strictly FIFO.
- A push while `count == 2` is impossible by construction. The bench asserts it never happens.

## Timing
- **Latency:** a transfer in cycle N makes the result visible as FIFO head in cycle N+1 when the FIFO was empty. Otherwise it queues behind older entries.
- **Throughput:** 1 result/cycle while `out_ready` stays high.
  - `count` settles at 1.
  - `req_ready` stays available every cycle.
- **Backpressure:** with `out_ready` low, two transfers fill the FIFO. `req_ready` is then 0 until a pop, and the pop cycle itself still shows `count == 2` to the arbiter. The accept resumes the cycle after the pop.
- **Reset state** (`rst_n` low at a clock edge):
  - `count = 0`, `rr_ptr = 0`;
  - `out_valid = 0`, `req_ready = 0`, `busy` tracks `req_valid` only;
  - `out_data`, `out_id`, `out_tag`, `out_dnm` are all 0;
  - queued results are discarded.
- **Reset during operation:** in the cycle `rst_n` is low, no transfer completes even if `req_valid` is high.
- **Requester obligations:** `req_data` and `req_tag` must stay stable while `req_valid` is high without ready. A requester may drop `req_valid` at any time; the grant moves on in the same cycle.

## Structure
- Reuse the FP32 and FP64 typedefs from the existing fp32Pkg and fp64Pkg packages.
- Add a small `fpCvtSchedPkg`. It holds:
  - the `cvt_entry_t` struct (FP64 data, id, tag, dnm);
  - `CVT_FIFO_DEPTH = 2`;
  - the bias-difference constant `11'h380`.
- The only sub-module is the existing `fpCvt32To64`, instantiated once and fed from a mux over the granted requester.
- The zero fixup lives in this block, not in the converter.
- The arbiter and FIFO are inline logic.

## Test plan
- **Single request:** `req_data[0] = 0x3F800000` (1.0), tag 3, `out_ready = 1`. Next cycle: `out_valid = 1`, `out_data = 0x3FF0000000000000`, id 0, tag 3, `dnm = 0`.
- **Fairness:** all 4 `req_valid` held high, `out_ready = 1`, 8 cycles. Grants follow 0,1,2,3,0,1,2,3 with one result per cycle.
- **Special values:** `0x7F800000` gives `0x7FF0000000000000`; `0xFFC00000` gives `0xFFF8000000000000`; `0x80000000` gives `0x8000000000000000` with dnm 0; `0x00000001` gives `0x0000000000000000` with dnm 1.
- **Backpressure:** `out_ready = 0`, requesters 1 and 2 valid. Two accepts, then `req_ready = 0` while held. Raise `out_ready`: results leave in order id 1 then id 2, and the accept resumes one cycle after the first pop.
- **Reset during traffic:** FIFO full, drop `rst_n` for one cycle. `out_valid = 0` and `rr_ptr = 0` after the edge. The next grant goes to requester 0 even if requester 3 is also valid.
